fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding fetches and queue entries (power of 2, >=2).
REQ-002 SHALL have parameter META_W, default 80, per-fetch sideband width: PC, exception flag/code, badvaddr, TLB-refill flag.
REQ-003 SHALL have parameter INST_W, default 32, instruction word width.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  pre-IF presents a fetch.
REQ-007 SHALL have port req_nocache  input  1  fetch carries an exception; no cache request is issued for it.
REQ-008 SHALL have port req_meta  input  META_W  sideband of the presented fetch.
REQ-009 SHALL have port req_allowin  output  1  fetch accepted this cycle; pre-IF issues its cache request only when req_valid&&req_allowin&&!req_nocache.
REQ-010 SHALL have port data_ok  input  1  in-order cache return strobe.
REQ-011 SHALL have port rdata  input  INST_W  returned instruction.
REQ-012 SHALL have port flush  input  1  exception or branch cancel; kills all queued fetches.
REQ-013 SHALL have port ds_allowin  input  1  decode accepts.
REQ-014 SHALL have port out_valid  output  1  head entry ready for decode.
REQ-015 SHALL have port out_bus  output  META_W+INST_W  {head meta, head inst}.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  live queue occupancy.

Function
REQ-017 SHALL hold a DEPTH-entry circular queue; each entry holds meta, inst and filled bit, with head/tail pointers that wrap modulo DEPTH.
REQ-018 SHALL assert req_allowin = !flush && count<DEPTH && inflight<DEPTH, where inflight counts issued-but-unreturned cache requests, including discarded ones.
REQ-019 SHALL push at tail on accept; a req_nocache entry is written filled with inst=0 and does not increment inflight.
REQ-020 SHALL drop data_ok and decrement discard while discard>0; otherwise it writes rdata into the oldest unfilled live entry and sets its filled bit.
REQ-021 SHALL drive out_valid = head live && (head filled || (head is oldest unfilled && data_ok && discard==0)); in the bypass case out_bus carries rdata the same cycle (zero-latency).
REQ-022 SHALL pop head when out_valid && ds_allowin && !flush.
REQ-023 SHALL handle simultaneous push and pop in one cycle, leaving count unchanged; with the queue full, a pop does not enable a same-cycle push (allowin uses registered count).
REQ-024 SHALL, on flush: clear all entries, reset count to 0, set discard to the inflight value after this cycle's data_ok, suppress out_valid, and block any push.
REQ-025 SHALL decrement inflight on every data_ok, whether kept or discarded, and increment it on every issued request; simultaneous increment and decrement nets to zero.
REQ-026 SHALL NOT leave data_ok unused when it arrives with inflight==0; this is a protocol error flagged by an assertion.

Reset
REQ-027 SHALL, under reset, clear count, inflight, discard, pointers and filled bits to 0, with out_valid=0 and out_bus=0 while empty.
REQ-028 SHALL, when reset arrives mid-operation, discard pending returns with no residue; the cache is reset on the same edge.
REQ-029 SHALL drive req_allowin=1 in the first cycle after reset.

Structure
REQ-030 SHALL take META_W field offsets (PC, exc flag, exc code, badvaddr, refill) from a shared mycpu package/header as named constants.
REQ-031 SHALL have one natural sub-module, fq_counter: a saturating up/down counter used for count, inflight and discard.
REQ-032 SHALL implement the queue storage as flops; no SRAM macro.

Verification
REQ-033 SHALL cover bypass: one fetch, data_ok 3 cycles later with rdata=0x24020001, ds_allowin=1 -> out_valid in that same cycle with inst 0x24020001, count returns to 0 next cycle.
REQ-034 SHALL cover full queue: 4 issues with no returns, DEPTH=4 -> req_allowin=0 and count=4; first data_ok with ds_allowin=1 -> the head pops and req_allowin=1 next cycle.
REQ-035 SHALL cover flush with 3 inflight, one data_ok in the same cycle -> discard=2; the next two returns are dropped and out_valid stays 0; the third return, after a new fetch, is delivered.
REQ-036 SHALL cover exception fetch: req_nocache=1 with exc code 0x04 -> delivered with inst 0, inflight unchanged, order preserved behind older pending fetches.
REQ-037 SHALL cover decode stall: ds_allowin=0 for 5 cycles while 4 returns arrive -> all are buffered, then delivered in issue order with no loss or duplication.
REQ-038 SHALL cover reset asserted with 2 inflight -> all counters 0, out_valid=0, and no stale instruction is delivered after reset.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared front-end definitions: layout of the per-fetch sideband word.
package fetch_queue_pkg;

  localparam int META_W_DEFAULT = 80;
  localparam int INST_W_DEFAULT = 32;

  // Sideband field offsets within req_meta / out_bus meta.
  localparam int PC_LSB        = 0;
  localparam int PC_W          = 32;
  localparam int EXC_FLAG_BIT  = 32;
  localparam int EXC_CODE_LSB  = 33;
  localparam int EXC_CODE_W    = 5;
  localparam int BADVADDR_LSB  = 38;
  localparam int BADVADDR_W    = 32;
  localparam int REFILL_BIT    = 70;

  function automatic logic [EXC_CODE_W-1:0] meta_exc_code(input logic [META_W_DEFAULT-1:0] meta);
    return meta[EXC_CODE_LSB +: EXC_CODE_W];
  endfunction

endpackage

// File: rtl/fq_counter.sv
// Saturating up/down counter with synchronous load; simultaneous inc and dec cancel.
module fq_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (inc && !dec && value != MAX_V) begin
      value <= value + 1'b1;
    end else if (dec && !inc && value != '0) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: tracks outstanding cache fetches in order and hands
// completed instructions to decode, with a zero-latency bypass for the head.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int META_W = META_W_DEFAULT,
  parameter int INST_W = INST_W_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic                       req_nocache,
  input  logic [META_W-1:0]          req_meta,
  output logic                       req_allowin,
  input  logic                       data_ok,
  input  logic [INST_W-1:0]          rdata,
  input  logic                       flush,
  input  logic                       ds_allowin,
  output logic                       out_valid,
  output logic [META_W+INST_W-1:0]   out_bus,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [META_W-1:0] meta_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  filled, filled_next;
  logic [DEPTH-1:0]  push_hit, pop_hit, fill_we;
  logic [PW-1:0]     head, tail, fill_idx;
  logic [CW-1:0]     inflight, discard;
  logic              push, issue, pop, rsp_keep, rsp_drop, fill_hit;
  logic              head_live, head_bypass;

  assign req_allowin = !flush && count < DEPTH_C && inflight < DEPTH_C;
  assign push        = req_valid && req_allowin;
  assign issue       = push && !req_nocache;
  assign rsp_drop    = data_ok && discard != '0;
  assign rsp_keep    = data_ok && discard == '0;

  // Oldest unfilled live entry: scan from head, nearest match wins.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count && !filled[head + PW'(i)]) begin
        fill_hit = 1'b1;
        fill_idx = head + PW'(i);
      end
    end
  end

  assign head_live   = count != '0;
  assign head_bypass = rsp_keep && fill_hit && fill_idx == head;
  assign out_valid   = !flush && head_live && (filled[head] || head_bypass);
  assign out_bus     = head_live ? {meta_mem[head], filled[head] ? inst_mem[head] : rdata} : '0;
  assign pop         = out_valid && ds_allowin;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign push_hit[gi] = push && tail == PW'(gi);
      assign pop_hit[gi]  = pop && head == PW'(gi);
      assign fill_we[gi]  = rsp_keep && fill_hit && fill_idx == PW'(gi);
      // A popped entry is never the push target: push needs a free slot.
      assign filled_next[gi] = flush        ? 1'b0 :
                               push_hit[gi] ? req_nocache :
                               pop_hit[gi]  ? 1'b0 :
                               fill_we[gi]  ? 1'b1 : filled[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      filled <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      filled <= filled_next;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        head <= head + PW'(pop);
        tail <= tail + PW'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_hit[i]) begin
        meta_mem[i] <= req_meta;
        inst_mem[i] <= '0;
      end else if (fill_we[i]) begin
        inst_mem[i] <= rdata;
      end
    end
  end

  fq_counter #(.W(CW), .MAX(DEPTH)) u_count (
    .clk(clk), .reset(reset), .load(flush), .load_val('0),
    .inc(push), .dec(pop), .value(count)
  );

  fq_counter #(.W(CW), .MAX(DEPTH)) u_inflight (
    .clk(clk), .reset(reset), .load(1'b0), .load_val('0),
    .inc(issue), .dec(data_ok), .value(inflight)
  );

  // Returns still owed for killed fetches must be swallowed after a flush.
  fq_counter #(.W(CW), .MAX(DEPTH)) u_discard (
    .clk(clk), .reset(reset), .load(flush), .load_val(inflight - CW'(data_ok)),
    .inc(1'b0), .dec(rsp_drop), .value(discard)
  );

  a_no_orphan_return: assert property (@(posedge clk) disable iff (reset)
    !(data_ok && inflight == '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MW = 80;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic reset, req_valid, req_nocache, data_ok, flush, ds_allowin;
  logic [MW-1:0] req_meta;
  logic [IW-1:0] rdata;
  logic req_allowin, out_valid;
  logic [MW+IW-1:0] out_bus;
  logic [$clog2(DEPTH):0] count;

  fetch_queue #(.DEPTH(DEPTH), .META_W(MW), .INST_W(IW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_nocache(req_nocache),
    .req_meta(req_meta), .req_allowin(req_allowin), .data_ok(data_ok), .rdata(rdata),
    .flush(flush), .ds_allowin(ds_allowin), .out_valid(out_valid), .out_bus(out_bus),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] meta;
    logic [IW-1:0] inst;
    bit            filled;
  } ent_t;

  typedef struct {
    bit rv; bit nc; logic [MW-1:0] meta; bit dok; logic [IW-1:0] rd; bit fl; bit ds;
    bit e_allow; bit e_ov; logic [IW-1:0] e_inst; int e_count;
  } vec_t;

  ent_t mq[$];
  int   m_inflight, m_discard;
  int   tests, fails;
  bit   obs_allow, obs_ov;
  logic [MW+IW-1:0] obs_bus;
  int   obs_count;
  vec_t tbl[16];

  function automatic logic [MW-1:0] mk_meta(input logic [31:0] pc, input bit exc, input logic [4:0] code);
    logic [MW-1:0] m;
    m = '0;
    m[PC_LSB +: PC_W] = pc;
    m[EXC_FLAG_BIT] = exc;
    m[EXC_CODE_LSB +: EXC_CODE_W] = code;
    m[BADVADDR_LSB +: BADVADDR_W] = pc;
    return m;
  endfunction

  function automatic logic [MW-1:0] pm(input int i);
    return mk_meta(32'hBFC0_0000 + 32'(i * 4), 1'b0, 5'd0);
  endfunction

  function automatic vec_t mkv(input bit rv, input logic [MW-1:0] meta, input bit dok,
                               input logic [IW-1:0] rd, input bit e_allow, input bit e_ov,
                               input int e_count);
    vec_t v;
    v.rv = rv; v.nc = 1'b0; v.meta = meta; v.dok = dok; v.rd = rd; v.fl = 1'b0; v.ds = 1'b1;
    v.e_allow = e_allow; v.e_ov = e_ov; v.e_inst = rd; v.e_count = e_count;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input bit rv, input bit nc, input logic [MW-1:0] meta, input bit dok,
                      input logic [IW-1:0] rd, input bit fl, input bit ds);
    int uf;
    bit kept, e_allow, e_ov;
    ent_t e;
    @(negedge clk);
    reset = 1'b0; req_valid = rv; req_nocache = nc; req_meta = meta;
    data_ok = dok; rdata = rd; flush = fl; ds_allowin = ds;
    #1;
    e_allow = !fl && mq.size() < DEPTH && m_inflight < DEPTH;
    uf = -1;
    foreach (mq[i]) if (uf < 0 && !mq[i].filled) uf = i;
    kept = dok && m_discard == 0;
    e_ov = !fl && mq.size() > 0 && (mq[0].filled || (uf == 0 && kept));
    chk("allowin", 128'(req_allowin), 128'(e_allow));
    chk("out_valid", 128'(out_valid), 128'(e_ov));
    chk("count", 128'(count), 128'(mq.size()));
    if (e_ov) chk("out_bus", 128'(out_bus), 128'({mq[0].meta, mq[0].filled ? mq[0].inst : rd}));
    obs_allow = req_allowin; obs_ov = out_valid; obs_bus = out_bus; obs_count = int'(count);
    if (fl) begin
      m_inflight -= int'(dok);
      m_discard = m_inflight;
      mq.delete();
    end else begin
      if (dok) begin
        m_inflight--;
        if (m_discard > 0) m_discard--;
        else if (uf >= 0) begin
          e = mq[uf]; e.inst = rd; e.filled = 1'b1; mq[uf] = e;
        end
      end
      if (e_ov && ds) begin
        $display("[TB] deliver pc=%h inst=%h", mq[0].meta[PC_LSB +: PC_W], mq[0].inst === '0 && !mq[0].filled ? rd : (mq[0].filled ? mq[0].inst : rd));
        void'(mq.pop_front());
      end
      if (rv && e_allow) begin
        e.meta = meta; e.inst = '0; e.filled = nc;
        mq.push_back(e);
        if (!nc) m_inflight++;
      end
    end
  endtask

  task automatic idle(input int n, input bit ds);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, ds);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b0; req_nocache = 1'b0; req_meta = '0;
    data_ok = 1'b0; rdata = '0; flush = 1'b0; ds_allowin = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_bus", 128'(out_bus), 128'(0));
    chk("rst_inflight", 128'(dut.inflight), 128'(0));
    chk("rst_discard", 128'(dut.discard), 128'(0));
    mq.delete();
    m_inflight = 0;
    m_discard = 0;
  endtask

  initial begin
    logic [MW-1:0] exm;
    tests = 0; fails = 0;
    do_reset();

    // Bypass delivery, then fill the queue and drain it.
    tbl[0]  = mkv(1, pm(0), 0, 32'h0,        1, 0, 0);
    tbl[1]  = mkv(0, '0,    0, 32'h0,        1, 0, 1);
    tbl[2]  = mkv(0, '0,    0, 32'h0,        1, 0, 1);
    tbl[3]  = mkv(0, '0,    1, 32'h24020001, 1, 1, 1);
    tbl[4]  = mkv(0, '0,    0, 32'h0,        1, 0, 0);
    tbl[5]  = mkv(1, pm(1), 0, 32'h0,        1, 0, 0);
    tbl[6]  = mkv(1, pm(2), 0, 32'h0,        1, 0, 1);
    tbl[7]  = mkv(1, pm(3), 0, 32'h0,        1, 0, 2);
    tbl[8]  = mkv(1, pm(4), 0, 32'h0,        1, 0, 3);
    tbl[9]  = mkv(1, pm(5), 0, 32'h0,        0, 0, 4);
    tbl[10] = mkv(0, '0,    1, 32'hA1,       0, 1, 4);
    tbl[11] = mkv(0, '0,    0, 32'h0,        1, 0, 3);
    tbl[12] = mkv(0, '0,    1, 32'hA2,       1, 1, 3);
    tbl[13] = mkv(0, '0,    1, 32'hA3,       1, 1, 2);
    tbl[14] = mkv(0, '0,    1, 32'hA4,       1, 1, 1);
    tbl[15] = mkv(0, '0,    0, 32'h0,        1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rv, tbl[i].nc, tbl[i].meta, tbl[i].dok, tbl[i].rd, tbl[i].fl, tbl[i].ds);
      chk($sformatf("tbl%0d_allow", i), 128'(obs_allow), 128'(tbl[i].e_allow));
      chk($sformatf("tbl%0d_ov", i), 128'(obs_ov), 128'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_count", i), 128'(obs_count), 128'(tbl[i].e_count));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_inst", i), 128'(obs_bus[IW-1:0]), 128'(tbl[i].e_inst));
    end

    // Flush with three in flight and a same-cycle return.
    for (int i = 0; i < 3; i++) step(1, 0, pm(10 + i), 0, '0, 0, 1);
    step(0, 0, '0, 1, 32'hDEAD0000, 1, 1);
    chk("flush_ov", 128'(obs_ov), 128'(0));
    step(1, 0, pm(13), 0, '0, 0, 1);
    chk("flush_discard", 128'(dut.discard), 128'(2));
    step(0, 0, '0, 1, 32'hDEAD0001, 0, 1);
    chk("drop1_ov", 128'(obs_ov), 128'(0));
    step(0, 0, '0, 1, 32'hDEAD0002, 0, 1);
    chk("drop2_ov", 128'(obs_ov), 128'(0));
    step(0, 0, '0, 1, 32'h24020003, 0, 1);
    chk("post_flush_bus", 128'(obs_bus), 128'({pm(13), 32'h24020003}));
    idle(1, 1);

    // Exception fetch queued behind an outstanding cached fetch.
    exm = mk_meta(32'hBFC0_0100, 1'b1, 5'h04);
    step(1, 0, pm(20), 0, '0, 0, 1);
    step(1, 1, exm, 0, '0, 0, 1);
    chk("exc_inflight", 128'(dut.inflight), 128'(1));
    step(0, 0, '0, 0, '0, 0, 1);
    chk("exc_order_ov", 128'(obs_ov), 128'(0));
    step(0, 0, '0, 1, 32'h11112222, 0, 1);
    chk("exc_older_bus", 128'(obs_bus), 128'({pm(20), 32'h11112222}));
    step(0, 0, '0, 0, '0, 0, 1);
    chk("exc_bus", 128'(obs_bus), 128'({exm, 32'h0}));
    chk("exc_code", 128'(meta_exc_code(obs_bus[MW+IW-1:IW])), 128'(5'h04));
    idle(1, 1);

    // Decode stall while all four returns arrive.
    for (int i = 0; i < 4; i++) step(1, 0, pm(30 + i), 0, '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 32'h3000 + 32'(i), 0, 0);
    idle(1, 0);
    chk("stall_count", 128'(count), 128'(4));
    for (int i = 0; i < 4; i++) begin
      step(0, 0, '0, 0, '0, 0, 1);
      chk($sformatf("stall_bus%0d", i), 128'(obs_bus), 128'({pm(30 + i), 32'h3000 + 32'(i)}));
    end
    idle(1, 1);
    chk("stall_empty", 128'(count), 128'(0));

    // Reset with two fetches outstanding.
    step(1, 0, pm(40), 0, '0, 0, 1);
    step(1, 0, pm(41), 0, '0, 0, 1);
    do_reset();
    idle(3, 1);
    step(1, 0, pm(42), 0, '0, 0, 1);
    step(0, 0, '0, 1, 32'h42424242, 0, 1);
    chk("post_reset_bus", 128'(obs_bus), 128'({pm(42), 32'h42424242}));

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(199) == 0) do_reset();
      else step($urandom_range(99) < 60, $urandom_range(99) < 20,
                {16'($urandom), $urandom, $urandom},
                m_inflight > 0 && $urandom_range(1) == 1, $urandom,
                $urandom_range(99) < 5, $urandom_range(99) < 70);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
